// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
// Package     : bp_pkg
// Description : Shared back-propagation definitions. Holds the sequencer
//               state encoding, the LSTM gate codes and the fixed-point
//               saturate helper, which the delta unit also uses.
// Revision    : 1.0 - initial release
// ============================================================================
package bp_pkg;

    // Sequencer states of the dot-product engine
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_WRITE = 2'd3
    } bp_state_t;

    // Gate select codes as seen on the delta-gate memory address
    localparam logic [1:0] GATE_A = 2'd0;
    localparam logic [1:0] GATE_I = 2'd1;
    localparam logic [1:0] GATE_F = 2'd2;
    localparam logic [1:0] GATE_O = 2'd3;

    // Clamp a signed value to the range of a w-bit two's-complement number.
    // The caller takes the low w bits of the result.
    function automatic logic signed [63:0] sat_fx(input logic signed [63:0] v,
                                                  input int unsigned        w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mac_sat.sv
`default_nettype none
// ============================================================================
// Module      : mac_sat
// Description : Signed fixed-point multiply, arithmetic shift by FRAC,
//               WIDTH+GUARD accumulator with clear/enable, and a registered
//               output stage. With DGATE_MAC_SAT_EN defined the output is
//               clamped to WIDTH bits; otherwise the low WIDTH bits are kept.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_sat
    import bp_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int FRAC  = 20,
    parameter int GUARD = 8
) (
    input  logic                    clk,
    input  logic                    rst,      // asynchronous, active-low
    input  logic                    i_clr,
    input  logic                    i_en,
    input  logic                    i_load,
    input  logic signed [WIDTH-1:0] i_a,
    input  logic signed [WIDTH-1:0] i_b,
    output logic        [WIDTH-1:0] o_data
);

    localparam int c_acc_w = WIDTH + GUARD;

    logic signed [2*WIDTH-1:0] w_prod;
    logic signed [2*WIDTH-1:0] w_prod_sh;
    logic signed [c_acc_w-1:0] w_term;
    logic signed [c_acc_w-1:0] w_acc_next;
    logic signed [c_acc_w-1:0] r_acc;
    logic        [WIDTH-1:0]   w_out;
    logic        [WIDTH-1:0]   r_data;

    // Full-precision product, then floor back to the operand's Q format
    assign w_prod     = (2*WIDTH)'(i_a) * (2*WIDTH)'(i_b);
    assign w_prod_sh  = w_prod >>> FRAC;
    assign w_term     = c_acc_w'(w_prod_sh);
    assign w_acc_next = r_acc + (i_en ? w_term : '0);

`ifdef DGATE_MAC_SAT_EN
    assign w_out = WIDTH'(sat_fx(64'(w_acc_next), WIDTH));
`else
    assign w_out = WIDTH'(w_acc_next);
`endif

    // Accumulator: clear has priority so a new row never sees stale sums
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_acc <= '0;
        else if (i_clr)
            r_acc <= '0;
        else
            r_acc <= w_acc_next;
    end

    // Result register: loads the sum including the operand arriving this cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_data <= '0;
        else if (i_load)
            r_data <= w_out;
    end

    assign o_data = r_data;

endmodule
`default_nettype wire

// File: rtl/dgate_mac.sv
`default_nettype none
// ============================================================================
// Module      : dgate_mac
// Description : Self-addressing back-propagation dot-product engine. For each
//               output row it walks the four delta gates (outer) and all
//               cells (inner), multiplies delta-gate by weight and writes the
//               row sum to the result memory. Start/done controlled.
//               Build option: DGATE_MAC_SAT_EN selects saturating output
//               conversion instead of two's-complement wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module dgate_mac
    import bp_pkg::*;
#(
    parameter int WIDTH  = 24,
    parameter int FRAC   = 20,
    parameter int N_CELL = 8,
    parameter int N_OUT  = 53,
    parameter int ADDR   = 12,
    parameter int GUARD  = 8
) (
    input  logic             clk,
    input  logic             rst,        // asynchronous, active-low
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dgate,
    input  logic [WIDTH-1:0] i_wght,
    output logic [1:0]       o_rd_gate,
    output logic [ADDR-1:0]  o_rd_cell,
    output logic [ADDR-1:0]  o_rd_row,
    output logic             o_wr,
    output logic [ADDR-1:0]  o_wr_addr,
    output logic [WIDTH-1:0] o_wr_data,
    output logic             o_busy,
    output logic             o_done
);

    localparam logic [ADDR-1:0] c_last_cell = ADDR'(N_CELL - 1);
    localparam logic [ADDR-1:0] c_last_row  = ADDR'(N_OUT - 1);

    bp_state_t       r_state;
    bp_state_t       w_state_next;
    logic [1:0]      r_gate;
    logic [ADDR-1:0] r_cell;
    logic [ADDR-1:0] r_row;
    logic            r_acc_en;
    logic            r_wr;
    logic            r_done;
    logic            r_busy;
    logic [ADDR-1:0] r_wr_addr;
    logic            w_last_addr;
    logic            w_wr_next;
    logic            w_done_next;
    logic            w_busy_next;
    logic            w_clr;
    logic            w_load;

    assign w_last_addr = (r_gate == GATE_O) && (r_cell == c_last_cell);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    // Next-state and control decode; strobes are registered below
    always_comb begin
        w_state_next = r_state;
        w_wr_next    = 1'b0;
        w_done_next  = 1'b0;
        w_clr        = 1'b0;
        w_load       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_next = ST_RUN;
                    w_clr        = 1'b1;
                end
            end
            ST_RUN: begin
                if (w_last_addr)
                    w_state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Last operand pair arrives now; capture the finished sum
                w_state_next = ST_WRITE;
                w_wr_next    = 1'b1;
                w_load       = 1'b1;
                w_done_next  = (r_row == c_last_row);
            end
            ST_WRITE: begin
                w_clr        = 1'b1;
                w_state_next = (r_row == c_last_row) ? ST_IDLE : ST_RUN;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_busy_next = (w_state_next != ST_IDLE);

    // Address counters: cell inner, gate outer, row advanced after each write
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gate <= GATE_A;
            r_cell <= '0;
            r_row  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_gate <= GATE_A;
                        r_cell <= '0;
                        r_row  <= '0;
                    end
                end
                ST_RUN: begin
                    if (r_cell == c_last_cell) begin
                        r_cell <= '0;
                        r_gate <= r_gate + 2'd1;
                    end else begin
                        r_cell <= r_cell + ADDR'(1);
                    end
                end
                ST_WRITE: r_row <= r_row + ADDR'(1);
                default: ;
            endcase
        end
    end

    // Operands return one cycle after their address, so delay the RUN valid
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_acc_en <= 1'b0;
        else
            r_acc_en <= (r_state == ST_RUN);
    end

    // Registered status and write strobes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr      <= 1'b0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
            r_wr_addr <= '0;
        end else begin
            r_wr   <= w_wr_next;
            r_done <= w_done_next;
            r_busy <= w_busy_next;
            if (w_load)
                r_wr_addr <= r_row;
        end
    end

    mac_sat #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC),
        .GUARD (GUARD)
    ) u_mac_sat (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_clr),
        .i_en   (r_acc_en),
        .i_load (w_load),
        .i_a    (i_dgate),
        .i_b    (i_wght),
        .o_data (o_wr_data)
    );

    assign o_rd_gate = r_gate;
    assign o_rd_cell = r_cell;
    assign o_rd_row  = r_row;
    assign o_wr      = r_wr;
    assign o_wr_addr = r_wr_addr;
    assign o_busy    = r_busy;
    assign o_done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_dgate_mac.sv
`default_nettype none
// ============================================================================
// Module      : tb_dgate_mac
// Description : Self-checking bench for dgate_mac (N_CELL=2, N_OUT=2).
//               Directed arithmetic cases plus random data against a
//               plain-arithmetic reference of the row dot products.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dgate_mac;

    localparam int W     = 24;
    localparam int FRAC  = 20;
    localparam int NC    = 2;
    localparam int NO    = 2;
    localparam int ADDR  = 12;
    localparam int GUARD = 8;
    localparam int ACC_W = W + GUARD;
    localparam int RC    = 4 * NC + 2;
    localparam int TOTAL = NO * RC;

    logic            clk;
    logic            rst;
    logic            i_start;
    logic [W-1:0]    i_dgate;
    logic [W-1:0]    i_wght;
    logic [1:0]      o_rd_gate;
    logic [ADDR-1:0] o_rd_cell;
    logic [ADDR-1:0] o_rd_row;
    logic            o_wr;
    logic [ADDR-1:0] o_wr_addr;
    logic [W-1:0]    o_wr_data;
    logic            o_busy;
    logic            o_done;

    logic [W-1:0] dg      [4][NC];
    logic [W-1:0] wt      [4][NO][NC];
    logic [W-1:0] exp_row [NO];

    int n_asserts = 0;
    int n_fail    = 0;

    dgate_mac #(
        .WIDTH  (W),
        .FRAC   (FRAC),
        .N_CELL (NC),
        .N_OUT  (NO),
        .ADDR   (ADDR),
        .GUARD  (GUARD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_start   (i_start),
        .i_dgate   (i_dgate),
        .i_wght    (i_wght),
        .o_rd_gate (o_rd_gate),
        .o_rd_cell (o_rd_cell),
        .o_rd_row  (o_rd_row),
        .o_wr      (o_wr),
        .o_wr_addr (o_wr_addr),
        .o_wr_data (o_wr_data),
        .o_busy    (o_busy),
        .o_done    (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memories: data valid one cycle after the address
    always @(posedge clk) begin
        int g, c, r;
        g = int'(o_rd_gate);
        c = int'(o_rd_cell);
        r = int'(o_rd_row);
        if (c < NC && r < NO) begin
            i_dgate <= dg[g][c];
            i_wght  <= wt[g][r][c];
        end else begin
            i_dgate <= '0;
            i_wght  <= '0;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_asserts++;
        assert (got === expv) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, expv);
        end
    endtask

    task automatic fill_const(input logic [W-1:0] dv, input logic [W-1:0] wv);
        for (int g = 0; g < 4; g++)
            for (int k = 0; k < NC; k++) begin
                dg[g][k] = dv;
                for (int j = 0; j < NO; j++)
                    wt[g][j][k] = wv;
            end
    endtask

    task automatic fill_rand();
        for (int g = 0; g < 4; g++)
            for (int k = 0; k < NC; k++) begin
                dg[g][k] = W'($urandom());
                for (int j = 0; j < NO; j++)
                    wt[g][j][k] = W'($urandom());
            end
    endtask

    // Reference: exact integer dot product with floored products,
    // accumulator wrap at ACC_W bits, then output conversion
    function automatic logic [W-1:0] model_row(input int j);
        longint sum;
        longint p;
        longint acc;
        logic [63:0] bits;
        sum = 0;
        for (int g = 0; g < 4; g++)
            for (int k = 0; k < NC; k++) begin
                p   = longint'(signed'(dg[g][k])) * longint'(signed'(wt[g][j][k]));
                sum = sum + (p >>> FRAC);
            end
        acc = (sum <<< (64 - ACC_W)) >>> (64 - ACC_W);
`ifdef DGATE_MAC_SAT_EN
        if (acc > longint'((1 << (W - 1)) - 1))
            acc = longint'((1 << (W - 1)) - 1);
        else if (acc < -longint'(1 << (W - 1)))
            acc = -longint'(1 << (W - 1));
`endif
        bits = 64'(acc);
        return bits[W-1:0];
    endfunction

    task automatic model_all();
        for (int j = 0; j < NO; j++)
            exp_row[j] = model_row(j);
    endtask

    // Starts a job from a negedge and checks every cycle of it.
    // glitch_cyc: cycle in which a spurious start is driven (0 = none)
    // abort_cyc : return at this cycle's negedge without finishing (0 = none)
    task automatic run_job(input string name, input int glitch_cyc, input int abort_cyc);
        int j, off;
        i_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_start = 1'b0;
        for (int cyc = 1; cyc <= TOTAL + 1; cyc++) begin
            if (cyc == abort_cyc)
                return;
            if (cyc <= TOTAL) begin
                j   = (cyc - 1) / RC;
                off = cyc - j * RC;
                check({name, ".busy"}, 64'(o_busy), 64'(1));
                check({name, ".wr"},   64'(o_wr),   64'(off == RC));
                check({name, ".done"}, 64'(o_done), 64'(cyc == TOTAL));
                if (off <= 4 * NC)
                    check({name, ".rd_addr"},
                          {30'd0, o_rd_gate, o_rd_cell, o_rd_row},
                          {30'd0, 2'((off - 1) / NC), ADDR'((off - 1) % NC), ADDR'(j)});
                if (off == RC) begin
                    check({name, ".wr_addr"}, 64'(o_wr_addr), 64'(j));
                    check({name, ".wr_data"}, 64'(o_wr_data), 64'(exp_row[j]));
                end else if (j > 0) begin
                    check({name, ".wr_data_hold"}, 64'(o_wr_data), 64'(exp_row[j-1]));
                end
            end else begin
                check({name, ".idle_busy"}, 64'(o_busy), 64'(0));
                check({name, ".idle_wr"},   64'(o_wr),   64'(0));
                check({name, ".idle_done"}, 64'(o_done), 64'(0));
                check({name, ".idle_hold"}, 64'(o_wr_data), 64'(exp_row[NO-1]));
            end
            i_start = (cyc == glitch_cyc);
            @(negedge clk);
        end
        i_start = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        check({name, ".rd"}, {26'd0, o_rd_gate, o_rd_cell, o_rd_row, o_wr, o_busy, o_done}, 64'd0);
        check({name, ".wr"}, {28'd0, o_wr_addr, o_wr_data}, 64'd0);
    endtask

    initial begin
        rst     = 1'b0;
        i_start = 1'b0;
        fill_const('0, '0);
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        @(negedge clk);

        // 1.0 * 0.5 over 8 terms = 4.0
        fill_const(24'h100000, 24'h080000);
        exp_row[0] = 24'h400000;
        exp_row[1] = 24'h400000;
        run_job("accum", 0, 0);

        // -1.0 * 0.25 over 8 terms = -2.0; spurious starts during RUN
        fill_const(24'hF00000, 24'h040000);
        exp_row[0] = 24'hE00000;
        exp_row[1] = 24'hE00000;
        run_job("neg_glitch_r0", 3, 0);
        run_job("neg_glitch_r1", RC + 5, 0);

        // 1 LSB * -0.5 floors to -1 LSB each; 8 terms = -8 LSB
        fill_const(24'h000001, 24'hF80000);
        exp_row[0] = 24'hFFFFF8;
        exp_row[1] = 24'hFFFFF8;
        run_job("trunc", 0, 0);

        // 7.0 * 7.0 over 8 terms = 392.0, far outside the output range
        fill_const(24'h700000, 24'h700000);
`ifdef DGATE_MAC_SAT_EN
        exp_row[0] = 24'h7FFFFF;
        exp_row[1] = 24'h7FFFFF;
`else
        exp_row[0] = 24'h800000;
        exp_row[1] = 24'h800000;
`endif
        run_job("overflow", 0, 0);

        // Random operands against the reference model
        for (int t = 0; t < 4; t++) begin
            fill_rand();
            model_all();
            run_job("random", 0, 0);
        end

        // Reset in the middle of row 1, then a fresh job from row 0
        fill_rand();
        model_all();
        run_job("pre_reset", 0, RC + 4);
        rst = 1'b0;
        #1;
        check_all_zero("mid_reset");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        fill_rand();
        model_all();
        run_job("post_reset", 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
